// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter sharing one uart_tx byte write port among NUM_REQ requesters.
// Define UART_ARB_TAG_EN to prepend a per-requester tag byte to every granted frame.
module uart_tx_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          TIMEOUT  = 1024,
  parameter logic [7:0]  TAG_BASE = 8'h30
) (
  input  logic                 i_clk,
  input  logic                 i_res,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  input  logic [NUM_REQ-1:0]   i_last,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_wen,
  output logic [7:0]           o_data,
  input  logic                 i_full,
  output logic                 o_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_XFER} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_XFER} state_t;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_next;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   w_gidx_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  logic [7:0]         w_lane [NUM_REQ];
  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_cand;
  int                 w_cand_int;
  logic               w_req_g;
  logic               w_last_g;
  logic               w_wen;
  logic [7:0]         w_data;
  logic [NUM_REQ-1:0] w_ack;
  logic               w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_lane[gi] = i_data[8*gi +: 8];
    end
  endgenerate

  // Search upward from the slot after the last owner so it ends up lowest priority.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_cand     = '0;
    w_cand_int = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand_int = (int'(r_ptr) + k) % NUM_REQ;
      w_cand     = IDX_W'(w_cand_int);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_req_g  = i_req[r_gidx];
  assign w_last_g = i_last[r_gidx];

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_gidx_next  = r_gidx;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_wen        = 1'b0;
    w_data       = 8'h00;
    w_ack        = '0;
    w_timeout    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_next = NUM_REQ'(1) << w_sel;
          w_gidx_next  = w_sel;
          w_cnt_next   = '0;
`ifdef UART_ARB_TAG_EN
          w_state_next = S_TAG;
`else
          w_state_next = S_XFER;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        w_wen      = ~i_full;
        w_data     = TAG_BASE + 8'(r_gidx);
        w_cnt_next = '0;
        if (!i_full) begin
          w_state_next = S_XFER;
        end
      end
`endif

      S_XFER: begin
        w_wen  = w_req_g & ~i_full;
        w_data = w_lane[r_gidx];
        w_ack  = w_wen ? r_grant : '0;
        if (w_wen && w_last_g) begin
          w_state_next = S_IDLE;
          w_grant_next = '0;
          w_ptr_next   = r_gidx;
          w_cnt_next   = '0;
        end else if (w_req_g) begin
          // A held request stalled by i_full is not idle time.
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
          w_grant_next = '0;
          w_ptr_next   = r_gidx;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_grant_next = '0;
        w_cnt_next   = '0;
      end
    endcase

    if (i_res) begin
      w_wen     = 1'b0;
      w_ack     = '0;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_gidx  <= w_gidx_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign o_wen     = w_wen;
  assign o_data    = w_data;
  assign o_ack     = w_ack;
  assign o_grant   = r_grant;
  assign o_timeout = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, frames, round-robin, backpressure, timeout, tag byte.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        res;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic        full;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        wen;
  logic [7:0]  odata;
  logic        tmo;

  int checks;
  int failures;

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .TIMEOUT (16),
    .TAG_BASE(8'h30)
  ) dut (
    .i_clk    (clk),
    .i_res    (res),
    .i_req    (req),
    .i_data   (data),
    .i_last   (last),
    .o_ack    (ack),
    .o_grant  (grant),
    .o_wen    (wen),
    .o_data   (odata),
    .i_full   (full),
    .o_timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic        exp_wen;
    logic [7:0]  exp_data;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_grant;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic apply(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l, input logic f);
    @(posedge clk);
    #1;
    req  = r;
    data = d;
    last = l;
    full = f;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic e_wen, input logic [7:0] e_data,
                            input logic [3:0] e_ack, input logic [3:0] e_grant, input logic e_to);
    chk({tag, ".wen"}, 32'(wen), 32'(e_wen));
    if (e_wen) chk({tag, ".data"}, 32'(odata), 32'(e_data));
    chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
    chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
    chk({tag, ".timeout"}, 32'(tmo), 32'(e_to));
    $display("%s: req=%b wen=%b data=%h ack=%b grant=%b to=%b", tag, req, wen, odata, ack, grant, tmo);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    res  = 1'b1;
    req  = '0;
    data = '0;
    last = '0;
    full = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  initial begin
    int owners [5];
    checks   = 0;
    failures = 0;
    res  = 1'b1;
    req  = 4'b1111;
    data = '0;
    last = '0;
    full = 1'b0;

    // Reset held with every requester active: nothing may be written or granted.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset.wen", 32'(wen), 32'd0);
      chk("reset.grant", 32'(grant), 32'd0);
      chk("reset.ack", 32'(ack), 32'd0);
    end
    @(posedge clk);
    #1;
    res = 1'b0;
    req = '0;

`ifndef UART_ARB_TAG_EN
    // Single 3-byte frame from req0, then a backpressured frame from req1 (req0 also asking).
    vecs.push_back('{4'b0001, 32'h00000041, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0001, 32'h00000041, 4'b0000, 1'b0, 1'b1, 8'h41, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'b0001, 32'h00000042, 4'b0000, 1'b0, 1'b1, 8'h42, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'b0001, 32'h00000043, 4'b0001, 1'b0, 1'b1, 8'h43, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0011, 32'h000051EE, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0011, 32'h000051EE, 4'b0000, 1'b0, 1'b1, 8'h51, 4'b0010, 4'b0010, 1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{4'b0011, 32'h000052EE, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0010, 1'b0});
    vecs.push_back('{4'b0011, 32'h000052EE, 4'b0010, 1'b0, 1'b1, 8'h52, 4'b0010, 4'b0010, 1'b0});
    vecs.push_back('{4'b0001, 32'h000000EE, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0001, 32'h000000EE, 4'b0001, 1'b0, 1'b1, 8'hEE, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});

    foreach (vecs[i]) begin
      apply(vecs[i].req, vecs[i].data, vecs[i].last, vecs[i].full);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_wen, vecs[i].exp_data,
                 vecs[i].exp_ack, vecs[i].exp_grant, vecs[i].exp_to);
    end

    // Round-robin: all four request continuously, 2-byte frames, grant order 0,1,2,3,0.
    owners = '{0, 1, 2, 3, 0};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      apply(4'b1111, 32'h63626160, 4'b0000, 1'b0);
      expect_out($sformatf("rr%0d.idle", f), 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
      apply(4'b1111, 32'h63626160, 4'b0000, 1'b0);
      expect_out($sformatf("rr%0d.b1", f), 1'b1, 8'(8'h60 + owners[f]),
                 4'(1 << owners[f]), 4'(1 << owners[f]), 1'b0);
      apply(4'b1111, 32'h73727170, 4'b1111, 1'b0);
      expect_out($sformatf("rr%0d.b2", f), 1'b1, 8'(8'h70 + owners[f]),
                 4'(1 << owners[f]), 4'(1 << owners[f]), 1'b0);
    end

    // Timeout: req1 writes one byte and goes quiet; revoked on the 16th idle cycle, then req2 wins.
    do_reset();
    apply(4'b0110, 32'h00A59900, 4'b0000, 1'b0);
    expect_out("to.idle", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
    apply(4'b0110, 32'h00A59900, 4'b0000, 1'b0);
    expect_out("to.byte", 1'b1, 8'h99, 4'b0010, 4'b0010, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      apply(4'b0100, 32'h00A59900, 4'b0000, 1'b0);
      expect_out($sformatf("to.wait%0d", c), 1'b0, 8'h00, 4'b0000, 4'b0010, (c == 16));
    end
    apply(4'b0100, 32'h00A59900, 4'b0100, 1'b0);
    expect_out("to.release", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
    apply(4'b0100, 32'h00A59900, 4'b0100, 1'b0);
    expect_out("to.req2", 1'b1, 8'hA5, 4'b0100, 4'b0100, 1'b0);
`else
    // Tag byte precedes req2's 1-byte frame and is not acknowledged.
    do_reset();
    apply(4'b0100, 32'h00550000, 4'b0100, 1'b0);
    expect_out("tag.idle", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
    apply(4'b0100, 32'h00550000, 4'b0100, 1'b0);
    expect_out("tag.tag", 1'b1, 8'h32, 4'b0000, 4'b0100, 1'b0);
    apply(4'b0100, 32'h00550000, 4'b0100, 1'b0);
    expect_out("tag.byte", 1'b1, 8'h55, 4'b0100, 4'b0100, 1'b0);
    apply(4'b0000, 32'h00000000, 4'b0000, 1'b0);
    expect_out("tag.done", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
